rom_streamer: RTL and testbench

ROM_STREAMER -- requirements
Module: rom_streamer

---
 rtl/rom_streamer_pkg.sv | 13 +
 rtl/stream_fifo2.sv | 51 +++++
 rtl/rom_streamer.sv | 156 +++++++++++++++
 tb/tb_rom_streamer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rom_streamer_pkg.sv
// rom_streamer_pkg: shared FSM state type and FIFO depth
// for the ROM burst streamer and its output FIFO.
package rom_streamer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/stream_fifo2.sv
// stream_fifo2: 2-entry FIFO holding data+last, head is registered.
// Ports: i_clk, i_rst (sync, high), i_push/i_data/i_last, i_pop,
// o_count (0..2), o_data/o_last (current head entry).
module stream_fifo2
   import rom_streamer_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_last,
   input  logic         i_pop,
   output logic [1:0]   o_count,
   output logic [W-1:0] o_data,
   output logic         o_last
);

   logic [W-1:0] r_data [FIFO_DEPTH];
   logic [1:0]   r_last;
   logic         r_wp;
   logic         r_rp;
   logic [1:0]   r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_data[0] <= '0;
         r_data[1] <= '0;
         r_last    <= '0;
         r_wp      <= 1'b0;
         r_rp      <= 1'b0;
         r_count   <= '0;
      end else begin
         if (i_push) begin
            r_data[r_wp] <= i_data;
            r_last[r_wp] <= i_last;
            r_wp         <= ~r_wp;
         end
         if (i_pop) begin
            r_rp <= ~r_rp;
         end
         r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
      end
   end

   assign o_count = r_count;
   assign o_data  = r_data[r_rp];
   assign o_last  = r_last[r_rp];

endmodule

// File: rtl/rom_streamer.sv
// rom_streamer: reads len words from a 1-cycle-latency ROM starting at
// base (address wraps) and streams them out with valid/ready/last.
// Ports: clk_i, rst_i (sync, high), start_i/base_addr_i/len_i request,
// busy_o/done_o status, rom_addr_o/rom_data_i ROM port,
// m_data_o/m_valid_o/m_ready_i/m_last_o stream.
// Macro ROM_STREAMER_PARITY_EN adds m_parity_o = XOR of m_data_o.
module rom_streamer
   import rom_streamer_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [ADDR_WIDTH:0]   len_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [ADDR_WIDTH-1:0] rom_addr_o,
   input  logic [DATA_WIDTH-1:0] rom_data_i,
   output logic [DATA_WIDTH-1:0] m_data_o,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic                  m_last_o
`ifdef ROM_STREAMER_PARITY_EN
   ,
   output logic                  m_parity_o
`endif
);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH:0]   r_len;
   logic [ADDR_WIDTH:0]   r_issued;
   logic                  r_infl;
   logic                  r_infl_last;
   logic                  r_done;

   logic [ADDR_WIDTH:0]   w_issued_inc;
   logic [1:0]            w_count;
   logic [DATA_WIDTH-1:0] w_head_data;
   logic                  w_head_last;
   logic                  w_pop;
   logic [2:0]            w_occ;
   logic                  w_issue;
   logic                  w_last_issue;
   logic                  w_accept;
   logic                  w_zero_req;
   logic                  w_last_beat;

   assign w_issued_inc = r_issued + {{ADDR_WIDTH{1'b0}}, 1'b1};
   assign m_valid_o    = (w_count != 2'd0);
   assign m_data_o     = w_head_data;
   // the head's last flag may be stale once the FIFO empties
   assign m_last_o     = m_valid_o & w_head_last;
   assign w_pop        = m_valid_o & m_ready_i;

   // slots already committed after this cycle's pop; a new read
   // is only issued if its data is guaranteed a FIFO slot
   assign w_occ = {1'b0, w_count} + {2'b0, r_infl} - {2'b0, w_pop};

   assign w_issue = (r_state == ST_RUN)
                  && (r_issued < r_len)
                  && (int'(w_occ) < FIFO_DEPTH);
   assign w_last_issue = w_issue && (w_issued_inc == r_len);

   assign w_accept    = (r_state == ST_IDLE) && start_i && (len_i != '0);
   assign w_zero_req  = (r_state == ST_IDLE) && start_i && (len_i == '0);
   assign w_last_beat = w_pop && m_last_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      busy_o      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            busy_o = 1'b1;
            if (w_last_issue) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            busy_o = 1'b1;
            if (w_last_beat) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // r_infl marks that rom_data_i this cycle answers a real read;
   // clearing it on reset drops data from an aborted burst
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_addr      <= '0;
         r_len       <= '0;
         r_issued    <= '0;
         r_infl      <= 1'b0;
         r_infl_last <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_infl      <= w_issue;
         r_infl_last <= w_last_issue;
         r_done      <= w_zero_req | ((r_state == ST_DRAIN) & w_last_beat);
         if (w_accept) begin
            r_addr   <= base_addr_i;
            r_len    <= len_i;
            r_issued <= '0;
         end else if (w_issue) begin
            r_addr   <= r_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            r_issued <= w_issued_inc;
         end
      end
   end

   assign rom_addr_o = r_addr;
   assign done_o     = r_done;

   stream_fifo2 #(
      .W(DATA_WIDTH)
   ) u_fifo (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_push  (r_infl),
      .i_data  (rom_data_i),
      .i_last  (r_infl_last),
      .i_pop   (w_pop),
      .o_count (w_count),
      .o_data  (w_head_data),
      .o_last  (w_head_last)
   );

`ifdef ROM_STREAMER_PARITY_EN
   assign m_parity_o = ^m_data_o;
`else
   // no parity output in this build
`endif

endmodule

// File: tb/tb_rom_streamer.sv
// tb_rom_streamer: directed bench for rom_streamer with a
// synchronous ROM model whose word at address a is a*7+3.
module tb_rom_streamer;

   logic       clk;
   logic       rst_i;
   logic       start_i;
   logic [7:0] base_addr_i;
   logic [8:0] len_i;
   logic       busy_o;
   logic       done_o;
   logic [7:0] rom_addr_o;
   logic [7:0] rom_data_i;
   logic [7:0] m_data_o;
   logic       m_valid_o;
   logic       m_ready_i;
   logic       m_last_o;
`ifdef ROM_STREAMER_PARITY_EN
   logic       m_parity_o;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   rom_streamer #(
      .DATA_WIDTH(8),
      .ADDR_WIDTH(8)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .base_addr_i (base_addr_i),
      .len_i       (len_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .rom_addr_o  (rom_addr_o),
      .rom_data_i  (rom_data_i),
      .m_data_o    (m_data_o),
      .m_valid_o   (m_valid_o),
      .m_ready_i   (m_ready_i),
      .m_last_o    (m_last_o)
`ifdef ROM_STREAMER_PARITY_EN
      ,
      .m_parity_o  (m_parity_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] rom_f(input logic [7:0] a);
      return 8'(a * 8'd7 + 8'd3);
   endfunction

   always @(posedge clk) rom_data_i <= rom_f(rom_addr_o);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // mode 0: ready held high; mode 1: ready 1,0,0,1 repeating
   task automatic burst(input logic [7:0] base, input int len,
                        input int mode, input int budget);
      int         k;
      int         lasts;
      int         cyc;
      bit         seen;
      bit         stall;
      logic [7:0] sd;
      logic       sl;
      logic [7:0] ea;
      k = 0; lasts = 0; cyc = 0; seen = 0; stall = 0;
      sd = '0; sl = 1'b0;
      base_addr_i = base;
      len_i       = 9'(len);
      start_i     = 1'b1;
      tick();
      start_i     = 1'b0;
      if (len > 0) check("busy_run", busy_o, 1);
      while (cyc < budget) begin
         if (done_o) begin
            seen = 1;
            break;
         end
         m_ready_i = (mode == 0) ? 1'b1 :
                     ((cyc % 4) == 0 || (cyc % 4) == 3);
         if (stall) begin
            check("stall_valid", m_valid_o, 1);
            check("stall_data", m_data_o, sd);
            check("stall_last", m_last_o, sl);
         end
         if (m_valid_o && m_ready_i) begin
            ea = 8'(base + 8'(k));
            check("beat_data", m_data_o, rom_f(ea));
            check("beat_last", m_last_o, (k == len - 1));
`ifdef ROM_STREAMER_PARITY_EN
            check("beat_par", m_parity_o, ^rom_f(ea));
`endif
            if (m_last_o) lasts++;
            k++;
         end
         stall = m_valid_o && !m_ready_i;
         sd    = m_data_o;
         sl    = m_last_o;
         tick();
         cyc++;
      end
      m_ready_i = 1'b1;
      check("done_seen", seen, 1);
      check("beat_count", k, len);
      check("last_count", lasts, (len > 0) ? 1 : 0);
      check("busy_idle", busy_o, 0);
      check("valid_idle", m_valid_o, 0);
      tick();
      check("done_pulse", done_o, 0);
   endtask

   initial begin
      rst_i       = 1'b1;
      start_i     = 1'b0;
      base_addr_i = '0;
      len_i       = '0;
      m_ready_i   = 1'b1;
      tick();
      tick();
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_valid", m_valid_o, 0);
      check("rst_last", m_last_o, 0);
      check("rst_data", m_data_o, 0);
      check("rst_addr", rom_addr_o, 0);
      rst_i = 1'b0;
      tick();

      // base 0x10, len 4: exact cycle timing
      base_addr_i = 8'h10;
      len_i       = 9'd4;
      start_i     = 1'b1;
      tick();
      start_i     = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         if (c <= 4) check("t_addr", rom_addr_o, 8'h10 + c - 1);
         if (c >= 3 && c <= 6) begin
            check("t_valid", m_valid_o, 1);
            check("t_data", m_data_o, rom_f(8'(8'h10 + c - 3)));
            check("t_last", m_last_o, (c == 6));
         end else begin
            check("t_novalid", m_valid_o, 0);
         end
         check("t_done", done_o, (c == 7));
         check("t_busy", busy_o, (c <= 6));
         tick();
      end
      check("t_done_end", done_o, 0);

      burst(8'hFE, 4, 0, 40);
      burst(8'h40, 8, 1, 200);
      burst(8'h00, 0, 0, 10);
      burst(8'h80, 256, 0, 600);

      // reset in cycle 5 of a len=16 burst
      base_addr_i = 8'h00;
      len_i       = 9'd16;
      start_i     = 1'b1;
      tick();
      start_i     = 1'b0;
      for (int c = 1; c < 5; c++) tick();
      check("mid_busy", busy_o, 1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check("abort_busy", busy_o, 0);
      check("abort_valid", m_valid_o, 0);
      check("abort_addr", rom_addr_o, 0);
      check("abort_data", m_data_o, 0);
      tick();
      check("abort_valid2", m_valid_o, 0);
      burst(8'h20, 2, 0, 40);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
